// File: rtl/mem_pkg.sv
// Shared types, funct3 encodings and the request legality check for the data memory.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Request fields captured when an access is accepted.
   typedef struct packed {
      logic        is_write;
      logic [2:0]  funct3;
      logic [1:0]  addr_lo;
      logic [31:0] wdata;
   } req_t;

   function automatic logic is_legal(input logic [2:0] funct3,
                                     input logic [1:0] addr_lo,
                                     input logic       is_write);
      logic ok;
      case (funct3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~addr_lo[0];
         F3_W:    ok = (addr_lo == 2'b00);
         F3_BU:   ok = ~is_write;
         F3_HU:   ok = ~is_write & ~addr_lo[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/data_memory_if.sv
// CPU MEM-stage to data memory request/response bundle.
interface data_memory_if;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [2:0]  MEM_FUNCT3;
   logic [31:0] MEM_ADDRESS;
   logic [31:0] MEM_WRITE_DATA;
   logic [31:0] READ_DATA;
   logic        BUSYWAIT;
   logic        ACCESS_ERR;

   modport master (
      output MEM_READ, MEM_WRITE, MEM_FUNCT3, MEM_ADDRESS, MEM_WRITE_DATA,
      input  READ_DATA, BUSYWAIT, ACCESS_ERR
   );

   modport slave (
      input  MEM_READ, MEM_WRITE, MEM_FUNCT3, MEM_ADDRESS, MEM_WRITE_DATA,
      output READ_DATA, BUSYWAIT, ACCESS_ERR
   );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/data placement and load extraction/extension.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be_c,
   output logic [31:0] wdata_lane_c,
   output logic [31:0] rdata_ext_c
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   // Store path: replicate data across lanes, enable only the addressed ones.
   always_comb begin
      be_c         = 4'b0000;
      wdata_lane_c = wdata;
      case (funct3)
         F3_B: begin
            be_c         = 4'b0001 << addr_lo;
            wdata_lane_c = {4{wdata[7:0]}};
         end
         F3_H: begin
            be_c         = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_lane_c = {2{wdata[15:0]}};
         end
         F3_W:    be_c = 4'b1111;
         default: be_c = 4'b0000;
      endcase
   end

   // Load path: pick the lane, then sign- or zero-extend.
   always_comb begin
      case (addr_lo)
         2'd0:    byte_c = rword[7:0];
         2'd1:    byte_c = rword[15:8];
         2'd2:    byte_c = rword[23:16];
         default: byte_c = rword[31:24];
      endcase
      half_c = addr_lo[1] ? rword[31:16] : rword[15:0];
      case (funct3)
         F3_B:    rdata_ext_c = {{24{byte_c[7]}}, byte_c};
         F3_H:    rdata_ext_c = {{16{half_c[15]}}, half_c};
         F3_BU:   rdata_ext_c = {24'd0, byte_c};
         F3_HU:   rdata_ext_c = {16'd0, half_c};
         default: rdata_ext_c = rword;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// Multi-cycle RV32 data memory: fixed-latency access FSM with byte/half/word loads and stores.
module data_memory
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 4
) (
   input  logic          CLK,
   input  logic          RESET,
   data_memory_if.slave  mem_if
);

   localparam int unsigned AW    = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   req_t             req_q, req_d;
   logic [AW-1:0]    widx_q, widx_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [31:0]      mem_q [DEPTH_WORDS];

   logic             busywait_c;
   logic             access_err_c;
   logic             mem_we_c;
   logic             rd_c, wr_c;
   logic [3:0]       be_c;
   logic [31:0]      wdata_lane_c;
   logic [31:0]      rdata_ext_c;
   logic             unused_addr_c;

   assign rd_c          = mem_if.MEM_READ;
   assign wr_c          = mem_if.MEM_WRITE;
   assign unused_addr_c = ^mem_if.MEM_ADDRESS[31:AW+2];

   mem_lane_align u_lane (
      .funct3       (req_q.funct3),
      .addr_lo      (req_q.addr_lo),
      .wdata        (req_q.wdata),
      .rword        (mem_q[widx_q]),
      .be_c         (be_c),
      .wdata_lane_c (wdata_lane_c),
      .rdata_ext_c  (rdata_ext_c)
   );

   // Next-state, latch capture and access strobe.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      widx_d       = widx_q;
      rdata_d      = rdata_q;
      busywait_c   = 1'b0;
      access_err_c = 1'b0;
      mem_we_c     = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_c ^ wr_c) begin
               if (is_legal(mem_if.MEM_FUNCT3, mem_if.MEM_ADDRESS[1:0], wr_c)) begin
                  busywait_c     = 1'b1;
                  req_d.is_write = wr_c;
                  req_d.funct3   = mem_if.MEM_FUNCT3;
                  req_d.addr_lo  = mem_if.MEM_ADDRESS[1:0];
                  req_d.wdata    = mem_if.MEM_WRITE_DATA;
                  widx_d         = mem_if.MEM_ADDRESS[AW+1:2];
                  cnt_d          = CNT_W'(LATENCY - 1);
                  state_d        = BUSY;
               end else begin
                  access_err_c = 1'b1;
               end
            end else if (rd_c && wr_c) begin
               access_err_c = 1'b1;
            end
         end
         BUSY: begin
            busywait_c = 1'b1;
            if (cnt_q == '0) begin
               state_d = DONE;
               if (req_q.is_write) mem_we_c = 1'b1;
               else                rdata_d  = rdata_ext_c;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         widx_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         widx_q  <= widx_d;
         rdata_q <= rdata_d;
      end
   end

   // Array is not reset; an abandoned access never reaches mem_we_c because state_q drops to IDLE.
   always_ff @(posedge CLK) begin
      if (mem_we_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be_c[i]) mem_q[widx_q][8*i +: 8] <= wdata_lane_c[8*i +: 8];
         end
      end
   end

   assign mem_if.READ_DATA  = rdata_q;
   assign mem_if.BUSYWAIT   = busywait_c;
   assign mem_if.ACCESS_ERR = access_err_c;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory (DEPTH_WORDS=256, LATENCY=4).
module tb_data_memory;

   localparam int unsigned LAT = 4;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   data_memory_if mem_if ();

   data_memory #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
      .CLK    (clk),
      .RESET  (rst_n),
      .mem_if (mem_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_bus();
      mem_if.MEM_READ       = 1'b0;
      mem_if.MEM_WRITE      = 1'b0;
      mem_if.MEM_FUNCT3     = 3'b000;
      mem_if.MEM_ADDRESS    = 32'd0;
      mem_if.MEM_WRITE_DATA = 32'd0;
   endtask

   // One CPU access held until BUSYWAIT drops; returns BUSYWAIT-high cycles, error flag and READ_DATA in DONE.
   task automatic access(input logic wr, input logic rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int busy, output logic err, output logic [31:0] rdata);
      @(negedge clk);
      mem_if.MEM_WRITE      = wr;
      mem_if.MEM_READ       = rd;
      mem_if.MEM_FUNCT3     = f3;
      mem_if.MEM_ADDRESS    = addr;
      mem_if.MEM_WRITE_DATA = wd;
      #1;
      err  = mem_if.ACCESS_ERR;
      busy = 0;
      while (mem_if.BUSYWAIT === 1'b1 && busy < 100) begin
         busy++;
         @(negedge clk);
         #1;
      end
      rdata = mem_if.READ_DATA;
      idle_bus();
   endtask

   task automatic test_reset();
      idle_bus();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (mem_if.READ_DATA !== 32'd0) begin
         n_bad++; $display("FAIL reset_read_data: got %h want %h", mem_if.READ_DATA, 32'd0);
      end
      n_cmp++;
      if (mem_if.BUSYWAIT !== 1'b0) begin
         n_bad++; $display("FAIL reset_busywait: got %b want 0", mem_if.BUSYWAIT);
      end
      n_cmp++;
      if (mem_if.ACCESS_ERR !== 1'b0) begin
         n_bad++; $display("FAIL reset_access_err: got %b want 0", mem_if.ACCESS_ERR);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_word();
      int b; logic e; logic [31:0] r;
      access(1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, b, e, r);
      n_cmp++;
      if (b !== LAT + 1 || e !== 1'b0) begin
         n_bad++; $display("FAIL sw_busy: got busy=%0d err=%b want busy=%0d err=0", b, e, LAT + 1);
      end
      access(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, b, e, r);
      n_cmp++;
      if (b !== LAT + 1) begin
         n_bad++; $display("FAIL lw_busy: got %0d want %0d", b, LAT + 1);
      end
      n_cmp++;
      if (r !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL lw_data: got %h want %h", r, 32'hDEADBEEF);
      end
   endtask

   task automatic test_byte();
      int b; logic e; logic [31:0] r;
      access(1'b1, 1'b0, 3'b000, 32'h13, 32'h00000080, b, e, r);
      n_cmp++;
      if (r !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL sb_keeps_read_data: got %h want %h", r, 32'hDEADBEEF);
      end
      access(1'b0, 1'b1, 3'b000, 32'h13, 32'h0, b, e, r);
      n_cmp++;
      if (r !== 32'hFFFFFF80) begin
         n_bad++; $display("FAIL lb: got %h want %h", r, 32'hFFFFFF80);
      end
      access(1'b0, 1'b1, 3'b100, 32'h13, 32'h0, b, e, r);
      n_cmp++;
      if (r !== 32'h00000080) begin
         n_bad++; $display("FAIL lbu: got %h want %h", r, 32'h00000080);
      end
      access(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, b, e, r);
      n_cmp++;
      if (r !== 32'h80ADBEEF) begin
         n_bad++; $display("FAIL lw_after_sb: got %h want %h", r, 32'h80ADBEEF);
      end
   endtask

   task automatic test_half();
      int b; logic e; logic [31:0] r;
      access(1'b1, 1'b0, 3'b010, 32'h20, 32'h11223344, b, e, r);
      access(1'b1, 1'b0, 3'b001, 32'h22, 32'hFFFF8001, b, e, r);
      access(1'b0, 1'b1, 3'b001, 32'h22, 32'h0, b, e, r);
      n_cmp++;
      if (r !== 32'hFFFF8001) begin
         n_bad++; $display("FAIL lh: got %h want %h", r, 32'hFFFF8001);
      end
      access(1'b0, 1'b1, 3'b101, 32'h22, 32'h0, b, e, r);
      n_cmp++;
      if (r !== 32'h00008001) begin
         n_bad++; $display("FAIL lhu: got %h want %h", r, 32'h00008001);
      end
      access(1'b0, 1'b1, 3'b001, 32'h21, 32'h0, b, e, r);
      n_cmp++;
      if (e !== 1'b1 || b !== 0) begin
         n_bad++; $display("FAIL lh_misaligned: got err=%b busy=%0d want err=1 busy=0", e, b);
      end
      access(1'b1, 1'b0, 3'b010, 32'h21, 32'hFFFFFFFF, b, e, r);
      n_cmp++;
      if (e !== 1'b1 || b !== 0) begin
         n_bad++; $display("FAIL sw_misaligned: got err=%b busy=%0d want err=1 busy=0", e, b);
      end
      access(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, b, e, r);
      n_cmp++;
      if (r !== 32'h80013344) begin
         n_bad++; $display("FAIL mem_unchanged_after_err: got %h want %h", r, 32'h80013344);
      end
   endtask

   task automatic test_illegal();
      int b; logic e; logic [31:0] r;
      access(1'b1, 1'b1, 3'b010, 32'h10, 32'h0, b, e, r);
      n_cmp++;
      if (e !== 1'b1 || b !== 0) begin
         n_bad++; $display("FAIL rd_and_wr: got err=%b busy=%0d want err=1 busy=0", e, b);
      end
      access(1'b0, 1'b1, 3'b011, 32'h10, 32'h0, b, e, r);
      n_cmp++;
      if (e !== 1'b1 || b !== 0) begin
         n_bad++; $display("FAIL f3_011: got err=%b busy=%0d want err=1 busy=0", e, b);
      end
      access(1'b1, 1'b0, 3'b100, 32'h10, 32'h0, b, e, r);
      n_cmp++;
      if (e !== 1'b1 || b !== 0) begin
         n_bad++; $display("FAIL store_f3_100: got err=%b busy=%0d want err=1 busy=0", e, b);
      end
      n_cmp++;
      if (r !== 32'h80013344) begin
         n_bad++; $display("FAIL read_data_after_err: got %h want %h", r, 32'h80013344);
      end
      access(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, b, e, r);
      n_cmp++;
      if (b !== LAT + 1 || r !== 32'h80ADBEEF) begin
         n_bad++; $display("FAIL access_after_err: got busy=%0d data=%h want busy=%0d data=%h",
                           b, r, LAT + 1, 32'h80ADBEEF);
      end
   endtask

   task automatic test_busy_ignore();
      int n;
      @(negedge clk);
      mem_if.MEM_READ    = 1'b1;
      mem_if.MEM_FUNCT3  = 3'b010;
      mem_if.MEM_ADDRESS = 32'h10;
      @(negedge clk);
      mem_if.MEM_FUNCT3  = 3'b011;
      mem_if.MEM_ADDRESS = 32'h21;
      #1;
      n_cmp++;
      if (mem_if.ACCESS_ERR !== 1'b0 || mem_if.BUSYWAIT !== 1'b1) begin
         n_bad++; $display("FAIL busy_err_masked: got err=%b bw=%b want err=0 bw=1",
                           mem_if.ACCESS_ERR, mem_if.BUSYWAIT);
      end
      n = 0;
      while (mem_if.BUSYWAIT === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      n_cmp++;
      if (n !== LAT || mem_if.READ_DATA !== 32'h80ADBEEF) begin
         n_bad++; $display("FAIL busy_inputs_ignored: got n=%0d data=%h want n=%0d data=%h",
                           n, mem_if.READ_DATA, LAT, 32'h80ADBEEF);
      end
      idle_bus();
   endtask

   task automatic test_reset_mid();
      int b; logic e; logic [31:0] r;
      access(1'b1, 1'b0, 3'b010, 32'h30, 32'hCAFEF00D, b, e, r);
      @(negedge clk);
      mem_if.MEM_WRITE      = 1'b1;
      mem_if.MEM_FUNCT3     = 3'b010;
      mem_if.MEM_ADDRESS    = 32'h30;
      mem_if.MEM_WRITE_DATA = 32'h12345678;
      repeat (2) @(negedge clk);
      idle_bus();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (mem_if.BUSYWAIT !== 1'b0 || mem_if.READ_DATA !== 32'd0) begin
         n_bad++; $display("FAIL reset_mid_busy: got bw=%b data=%h want bw=0 data=0",
                           mem_if.BUSYWAIT, mem_if.READ_DATA);
      end
      @(negedge clk);
      rst_n = 1'b1;
      access(1'b0, 1'b1, 3'b010, 32'h30, 32'h0, b, e, r);
      n_cmp++;
      if (r !== 32'hCAFEF00D) begin
         n_bad++; $display("FAIL write_abandoned: got %h want %h", r, 32'hCAFEF00D);
      end
   endtask

   task automatic test_wrap();
      int b; logic e; logic [31:0] r;
      access(1'b1, 1'b0, 3'b010, 32'h400, 32'hA5A5A5A5, b, e, r);
      access(1'b0, 1'b1, 3'b010, 32'h000, 32'h0, b, e, r);
      n_cmp++;
      if (r !== 32'hA5A5A5A5) begin
         n_bad++; $display("FAIL wrap_0x400: got %h want %h", r, 32'hA5A5A5A5);
      end
      access(1'b0, 1'b1, 3'b010, 32'hFFFFFC10, 32'h0, b, e, r);
      n_cmp++;
      if (r !== 32'h80ADBEEF) begin
         n_bad++; $display("FAIL wrap_high_bits: got %h want %h", r, 32'h80ADBEEF);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      idle_bus();
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_illegal();
      test_busy_ignore();
      test_reset_mid();
      test_wrap();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/data_memory.md
# data_memory

Multi-cycle data memory for the RV32IM pipelined CPU, sitting directly downstream of the CPU's MEM stage. It consumes the CPU's MEM_READ, MEM_WRITE, MEM_ADDRESS and MEM_WRITE_DATA, and returns READ_DATA. It stalls the pipeline with BUSYWAIT for a fixed access latency and performs RV32 byte, halfword and word loads and stores, with load sign or zero extension.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words. Power of two.
- LATENCY, 4: cycles spent in BUSY per access. Must be ≥1.

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-low reset (asserted when 0)
- MEM_READ  in  1  load request
- MEM_WRITE  in  1  store request
- MEM_FUNCT3  in  3  RV32 load/store funct3 (size/sign)
- MEM_ADDRESS  in  32  byte address
- MEM_WRITE_DATA  in  32  store data (low bytes used for SB/SH)
- READ_DATA  out  32  extended load result; registered
- BUSYWAIT  out  1  stall request to the CPU
- ACCESS_ERR  out  1  request rejected (misaligned, illegal funct3, or both read and write)

## Operation
- States: IDLE, BUSY, DONE.
- A request is MEM_READ^MEM_WRITE in IDLE.
- It is legal when:
  - funct3 ∈ {000,001,010,100,101} for a read, or {000,001,010} for a write;
  - halfword has addr[0]=0;
  - word has addr[1:0]=0.
- IDLE, legal request: BUSYWAIT=1 combinationally.
  - At the edge: latch address, data, funct3 and direction.
  - Counter ← LATENCY-1; go to BUSY.
- IDLE, illegal request, or MEM_READ&MEM_WRITE: ACCESS_ERR=1 combinationally, BUSYWAIT=0, no access, stay IDLE.
- BUSY: BUSYWAIT=1; counter decrements each edge.
  - At the edge with counter==0, perform the access and go to DONE.
  - Read: READ_DATA ← extended lane.
  - Write: update the selected byte lanes only.
- DONE: BUSYWAIT=0, requests ignored (the CPU still holds its request this cycle); → IDLE at the next edge.
- Little-endian byte order. Word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo 4·DEPTH_WORDS.
- Load extension:
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: unchanged.
- READ_DATA holds its value until the next completed read; writes do not change it.
- Reset: state=IDLE, counter=0, READ_DATA=0, BUSYWAIT=0, ACCESS_ERR=0. Array contents are not cleared.
  - Reset mid-BUSY abandons the access; a pending write is not performed.

## Timing
- Legal access: BUSYWAIT is high for exactly LATENCY+1 cycles, from the request cycle through the last BUSY cycle.
- READ_DATA is valid in the DONE cycle and after.
- Back-to-back accesses: minimum LATENCY+2 cycles per access (IDLE, L×BUSY, DONE).
- ACCESS_ERR is purely combinational in IDLE and never asserted in BUSY or DONE.
- BUSYWAIT is combinational only in IDLE; in BUSY/DONE it is decoded from state.
- Request inputs change during BUSY: ignored, because latched values are used.

## Structure
- Package mem_pkg:
  - state enum {IDLE, BUSY, DONE};
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - legality function is_legal(funct3, addr_lo, is_write).
- Sub-module mem_lane_align, purely combinational:
  - store path: (funct3, addr[1:0], wdata) → byte enables plus lane-shifted data;
  - load path: (funct3, addr[1:0], word) → extended result.
- Top holds the FSM, counter, latches and word array.

## Test plan
- Reset, then SW 0xDEADBEEF @0x10, then LW @0x10 (LATENCY=4): BUSYWAIT high 5 cycles per access; READ_DATA=0xDEADBEEF in DONE.
- SB 0x80 @0x13 after that word; then LB @0x13 → 0xFFFFFF80, LBU @0x13 → 0x00000080, LW @0x10 → 0x80ADBEEF.
- SH 0x8001 @0x22, then LH @0x22 → 0xFFFF8001 and LHU → 0x00008001. LH @0x21: ACCESS_ERR=1, BUSYWAIT=0, memory unchanged.
- MEM_READ&MEM_WRITE both 1, and MEM_FUNCT3=011: ACCESS_ERR=1, no state change.
- SW 0x12345678 @0x30; pulse RESET low in the 2nd BUSY cycle; then LW @0x30 returns the prior contents; after reset, READ_DATA=0 and BUSYWAIT=0.
- DEPTH_WORDS=256, SW 0xA5A5A5A5 @0x400, then LW @0x000 → 0xA5A5A5A5 (wrap).
